// File: rtl/fp_wb_queue_pkg.sv
// Shared types and constants for the FP writeback queue.
// One entry is {bank, dst[3:0], data[31:0]} = 37 bits.
package fp_wb_queue_pkg;

  localparam int FPWB_DEPTH = 4;
  localparam int ENTRY_W    = 37;

  typedef struct packed {
    logic        bank;
    logic [3:0]  dst;
    logic [31:0] data;
  } wb_entry_t;

  // One-hot busy-vector position for a register, indexed by {bank,dst}.
  function automatic logic [31:0] reg_onehot(input logic bank, input logic [3:0] dst);
    logic [31:0] r;
    r = '0;
    r[{bank, dst}] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_wb_fifo2w2r.sv
// Circular entry store with two pushes and two pops per cycle.
// Slot 1 of a push/pop pair lands after slot 0 only when slot 0 is active.
module fp_wb_fifo2w2r
  import fp_wb_queue_pkg::*;
#(
  parameter int DEPTH = FPWB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push0_i,
  input  wb_entry_t     push_data0_i,
  input  logic          push1_i,
  input  wb_entry_t     push_data1_i,
  input  logic          pop0_i,
  input  logic          pop1_i,
  output wb_entry_t     rd_data0_o,
  output wb_entry_t     rd_data1_o,
  output logic [CW-1:0] count_o
);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_idx1;
  logic [PW-1:0]   rd_idx1;

  always_comb begin
    wr_idx1 = wptr_q + PW'(push0_i);
    rd_idx1 = rptr_q + PW'(1);
    wptr_d  = wptr_q + PW'(push0_i) + PW'(push1_i);
    rptr_d  = rptr_q + PW'(pop0_i) + PW'(pop1_i);
    count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop0_i) - CW'(pop1_i);
  end

  // Storage carries no reset; only pointers and occupancy do.
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wptr_q]  <= push_data0_i;
    if (push1_i) mem_q[wr_idx1] <= push_data1_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rd_data0_o = mem_q[rptr_q];
  assign rd_data1_o = mem_q[rd_idx1];
  assign count_o    = count_q;

endmodule

// File: rtl/fp_wb_queue.sv
// FP writeback queue: merges FPU and load results into two registered RF write
// ports and tracks pending destination writes in a busy scoreboard.
module fp_wb_queue
  import fp_wb_queue_pkg::*;
#(
  parameter int DEPTH = FPWB_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [3:0]    issue_dst,
  input  logic          issue_bank,
  input  logic          fpu_valid,
  input  logic [3:0]    fpu_dst,
  input  logic          fpu_bank,
  input  logic [31:0]   fpu_data,
  output logic          fpu_ready,
  input  logic          ld_valid,
  input  logic [3:0]    ld_dst,
  input  logic          ld_bank,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  output logic          rf_wen0,
  output logic [3:0]    rf_wdst0,
  output logic          rf_wbank0,
  output logic [31:0]   rf_wdata0,
  output logic          rf_wen1,
  output logic [3:0]    rf_wdst1,
  output logic          rf_wbank1,
  output logic [31:0]   rf_wdata1,
  output logic [31:0]   busy,
  output logic [CW-1:0] wb_count
);

  // Handshake: a source transfers on a rising edge when valid && ready and
  // holds valid/payload until then; ready depends only on registered occupancy.
  logic      space_ok;
  logic      fpu_push, ld_push;
  logic      pop0, pop1;
  wb_entry_t fpu_entry, ld_entry;
  wb_entry_t rd0, rd1;

  wb_entry_t   out0_q, out0_d, out1_q, out1_d;
  logic        wen0_q, wen0_d, wen1_q, wen1_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] set_mask, clr_mask;

  assign space_ok  = (wb_count <= CW'(DEPTH - 2));
  assign fpu_ready = space_ok;
  assign ld_ready  = space_ok;
  assign fpu_push  = fpu_valid & space_ok;
  assign ld_push   = ld_valid & space_ok;
  assign fpu_entry = '{bank: fpu_bank, dst: fpu_dst, data: fpu_data};
  assign ld_entry  = '{bank: ld_bank, dst: ld_dst, data: ld_data};

  // Drain as much as possible every cycle: oldest to port 0, next to port 1.
  assign pop0 = (wb_count != '0);
  assign pop1 = (wb_count >= CW'(2));

  fp_wb_fifo2w2r #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push0_i      (fpu_push),
    .push_data0_i (fpu_entry),
    .push1_i      (ld_push),
    .push_data1_i (ld_entry),
    .pop0_i       (pop0),
    .pop1_i       (pop1),
    .rd_data0_o   (rd0),
    .rd_data1_o   (rd1),
    .count_o      (wb_count)
  );

  always_comb begin
    out0_d   = '0;
    out1_d   = '0;
    wen0_d   = pop0;
    wen1_d   = pop1;
    set_mask = '0;
    clr_mask = '0;
    if (pop0) begin
      out0_d   = rd0;
      clr_mask = clr_mask | reg_onehot(rd0.bank, rd0.dst);
    end
    if (pop1) begin
      out1_d   = rd1;
      clr_mask = clr_mask | reg_onehot(rd1.bank, rd1.dst);
    end
    if (issue_valid) set_mask = reg_onehot(issue_bank, issue_dst);
    // A clear lands on the same edge the write is loaded onto rf_wen; set wins.
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q <= '0;
      out1_q <= '0;
      wen0_q <= 1'b0;
      wen1_q <= 1'b0;
      busy_q <= '0;
    end else begin
      out0_q <= out0_d;
      out1_q <= out1_d;
      wen0_q <= wen0_d;
      wen1_q <= wen1_d;
      busy_q <= busy_d;
    end
  end

  assign rf_wen0   = wen0_q;
  assign rf_wdst0  = out0_q.dst;
  assign rf_wbank0 = out0_q.bank;
  assign rf_wdata0 = out0_q.data;
  assign rf_wen1   = wen1_q;
  assign rf_wdst1  = out1_q.dst;
  assign rf_wbank1 = out1_q.bank;
  assign rf_wdata1 = out1_q.data;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_wb_queue.sv
// Bench for fp_wb_queue: directed scenarios plus random traffic, with an
// in-order expected-write queue checked on every RF write port pulse.
module tb_fp_wb_queue;
  import fp_wb_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, rst_n;
  logic          issue_valid, issue_bank;
  logic [3:0]    issue_dst;
  logic          fpu_valid, fpu_bank, fpu_ready;
  logic [3:0]    fpu_dst;
  logic [31:0]   fpu_data;
  logic          ld_valid, ld_bank, ld_ready;
  logic [3:0]    ld_dst;
  logic [31:0]   ld_data;
  logic          rf_wen0, rf_wbank0, rf_wen1, rf_wbank1;
  logic [3:0]    rf_wdst0, rf_wdst1;
  logic [31:0]   rf_wdata0, rf_wdata1;
  logic [31:0]   busy;
  logic [CW-1:0] wb_count;

  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf [32];
  int          n_tests, n_fail;
  logic        mon_en;

  fp_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_bank(issue_bank),
    .fpu_valid(fpu_valid), .fpu_dst(fpu_dst), .fpu_bank(fpu_bank), .fpu_data(fpu_data),
    .fpu_ready(fpu_ready),
    .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_bank(ld_bank), .ld_data(ld_data),
    .ld_ready(ld_ready),
    .rf_wen0(rf_wen0), .rf_wdst0(rf_wdst0), .rf_wbank0(rf_wbank0), .rf_wdata0(rf_wdata0),
    .rf_wen1(rf_wen1), .rf_wdst1(rf_wdst1), .rf_wbank1(rf_wbank1), .rf_wdata1(rf_wdata1),
    .busy(busy), .wb_count(wb_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (rf_wen0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_port0 unexpected write got=%h expected=none", {rf_wbank0, rf_wdst0, rf_wdata0});
        end else begin
          mon_exp = exp_q.pop_front();
          if ({rf_wbank0, rf_wdst0, rf_wdata0} !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_port0 got=%h expected=%h", {rf_wbank0, rf_wdst0, rf_wdata0}, mon_exp);
          end
        end
        dut_rf[{rf_wbank0, rf_wdst0}] = rf_wdata0;
      end
      if (rf_wen1) begin
        n_tests++;
        if (!rf_wen0) begin
          n_fail++;
          $display("FAIL sb_port1_alone got rf_wen0=0 expected rf_wen0=1");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_port1 unexpected write got=%h expected=none", {rf_wbank1, rf_wdst1, rf_wdata1});
        end else begin
          mon_exp = exp_q.pop_front();
          if ({rf_wbank1, rf_wdst1, rf_wdata1} !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_port1 got=%h expected=%h", {rf_wbank1, rf_wdst1, rf_wdata1}, mon_exp);
          end
        end
        dut_rf[{rf_wbank1, rf_wdst1}] = rf_wdata1;
      end
    end
  end

  // Driver: record transfers that will happen on the coming edge, then advance.
  task automatic commit_and_step(output bit f_done, output bit l_done);
    f_done = fpu_valid && fpu_ready;
    l_done = ld_valid && ld_ready;
    if (f_done) begin
      exp_q.push_back({fpu_bank, fpu_dst, fpu_data});
      model_rf[{fpu_bank, fpu_dst}] = fpu_data;
    end
    if (l_done) begin
      exp_q.push_back({ld_bank, ld_dst, ld_data});
      model_rf[{ld_bank, ld_dst}] = ld_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit f, l;
    commit_and_step(f, l);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rf_wen0, rf_wen1, busy, wb_count, rf_wdst0, rf_wbank0, rf_wdata0, rf_wdst1, rf_wbank1, rf_wdata1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got wen=%b%b busy=%h cnt=%0d d0=%h d1=%h expected all zero",
               rf_wen0, rf_wen1, busy, wb_count, rf_wdata0, rf_wdata1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_tests++;
    if ({fpu_ready, ld_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready got=%b%b expected=11", fpu_ready, ld_ready);
    end
  endtask

  task automatic test_single();
    fpu_valid = 1'b1; fpu_dst = 4'd3; fpu_bank = 1'b0; fpu_data = 32'h3F80_0000;
    step();
    fpu_valid = 1'b0;
    n_tests++;
    if (rf_wen0 !== 1'b0 || wb_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_latency got wen0=%b cnt=%0d expected wen0=0 cnt=1", rf_wen0, wb_count);
    end
    step();
    n_tests++;
    if ({rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0, rf_wen1} !== {1'b1, 4'd3, 1'b0, 32'h3F80_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL single_write got wen0=%b dst=%0d bank=%b data=%h wen1=%b expected 1/3/0/3f800000/0",
               rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0, rf_wen1);
    end
    step();
    n_tests++;
    if (rf_wen0 !== 1'b0 || wb_count !== '0) begin
      n_fail++;
      $display("FAIL single_idle got wen0=%b cnt=%0d expected 0/0", rf_wen0, wb_count);
    end
  endtask

  task automatic test_pair();
    fpu_valid = 1'b1; fpu_dst = 4'd5; fpu_bank = 1'b1; fpu_data = 32'hAAAA_0000;
    ld_valid  = 1'b1; ld_dst  = 4'd5; ld_bank  = 1'b1; ld_data  = 32'h5555_FFFF;
    step();
    fpu_valid = 1'b0; ld_valid = 1'b0;
    step();
    n_tests++;
    if ({rf_wen0, rf_wbank0, rf_wdst0, rf_wdata0} !== {1'b1, 1'b1, 4'd5, 32'hAAAA_0000} ||
        {rf_wen1, rf_wbank1, rf_wdst1, rf_wdata1} !== {1'b1, 1'b1, 4'd5, 32'h5555_FFFF}) begin
      n_fail++;
      $display("FAIL pair_order got p0=%b/%b/%0d/%h p1=%b/%b/%0d/%h expected p0 aaaa0000 p1 5555ffff bank1 dst5",
               rf_wen0, rf_wbank0, rf_wdst0, rf_wdata0, rf_wen1, rf_wbank1, rf_wdst1, rf_wdata1);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit f, l;
    int xfers = 0;
    int cyc = 0;
    int exp_cnt;
    fpu_valid = 1'b1; fpu_dst = 4'($urandom_range(0, 15)); fpu_bank = 1'($urandom_range(0, 1)); fpu_data = $urandom;
    ld_valid  = 1'b1; ld_dst  = 4'($urandom_range(0, 15)); ld_bank  = 1'($urandom_range(0, 1)); ld_data  = $urandom;
    while (xfers < 16 && cyc < 40) begin
      commit_and_step(f, l);
      cyc++;
      xfers += int'(f) + int'(l);
      if (f) begin fpu_dst = 4'($urandom_range(0, 15)); fpu_bank = 1'($urandom_range(0, 1)); fpu_data = $urandom; end
      if (l) begin ld_dst = 4'($urandom_range(0, 15)); ld_bank = 1'($urandom_range(0, 1)); ld_data = $urandom; end
      if (xfers >= 16) begin fpu_valid = 1'b0; ld_valid = 1'b0; end
      exp_cnt = exp_q.size() - int'(rf_wen0) - int'(rf_wen1);
      n_tests++;
      if (int'(wb_count) !== exp_cnt || wb_count > CW'(DEPTH) ||
          fpu_ready !== (DEPTH - exp_cnt >= 2) || ld_ready !== (DEPTH - exp_cnt >= 2)) begin
        n_fail++;
        $display("FAIL b2b_count got cnt=%0d rdy=%b%b expected cnt=%0d rdy=%b",
                 wb_count, fpu_ready, ld_ready, exp_cnt, (DEPTH - exp_cnt >= 2));
      end
    end
    fpu_valid = 1'b0; ld_valid = 1'b0;
    n_tests++;
    if (xfers != 16) begin
      n_fail++;
      $display("FAIL b2b_transfers got=%0d expected=16 within 40 cycles", xfers);
    end
    repeat (4) step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain got pending=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_busy();
    n_tests++;
    if (busy !== '0) begin
      n_fail++;
      $display("FAIL busy_initial got=%h expected=0", busy);
    end
    issue_valid = 1'b1; issue_dst = 4'd7; issue_bank = 1'b1;
    step();
    issue_valid = 1'b0;
    n_tests++;
    if (busy !== 32'h0080_0000) begin
      n_fail++;
      $display("FAIL busy_set got=%h expected=00800000", busy);
    end
    fpu_valid = 1'b1; fpu_dst = 4'd7; fpu_bank = 1'b1; fpu_data = 32'h1234_5678;
    step();
    fpu_valid = 1'b0;
    n_tests++;
    if (busy[23] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_pending got=%b expected=1", busy[23]);
    end
    step();
    n_tests++;
    if (rf_wen0 !== 1'b1 || busy[23] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_clear got wen0=%b busy23=%b expected 1/0", rf_wen0, busy[23]);
    end
    // Issue and write together, then reissue on the edge the write is presented.
    issue_valid = 1'b1; fpu_valid = 1'b1; fpu_data = 32'hCAFE_0001;
    step();
    fpu_valid = 1'b0;
    step();
    issue_valid = 1'b0;
    n_tests++;
    if (rf_wen0 !== 1'b1 || busy[23] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_set_wins got wen0=%b busy23=%b expected 1/1", rf_wen0, busy[23]);
    end
    fpu_valid = 1'b1; fpu_data = 32'hCAFE_0002;
    step();
    fpu_valid = 1'b0;
    step();
    // Loads clear busy but never set it.
    issue_valid = 1'b1; issue_dst = 4'd2; issue_bank = 1'b0;
    ld_valid = 1'b1; ld_dst = 4'd9; ld_bank = 1'b0; ld_data = 32'h0BAD_F00D;
    step();
    issue_valid = 1'b0; ld_valid = 1'b0;
    step();
    n_tests++;
    if (busy !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL busy_ld_noset got=%h expected=00000004", busy);
    end
    ld_valid = 1'b1; ld_dst = 4'd2; ld_bank = 1'b0; ld_data = 32'h0000_0222;
    step();
    ld_valid = 1'b0;
    step();
    n_tests++;
    if (busy !== '0) begin
      n_fail++;
      $display("FAIL busy_ld_clear got=%h expected=0", busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_dst = 4'd1; issue_bank = 1'b0;
    fpu_valid = 1'b1; fpu_dst = 4'd1; fpu_bank = 1'b0; fpu_data = 32'h1111_1111;
    ld_valid  = 1'b1; ld_dst  = 4'd4; ld_bank  = 1'b1; ld_data  = 32'h4444_4444;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    issue_valid = 1'b0; fpu_valid = 1'b0; ld_valid = 1'b0;
    exp_q.delete();
    n_tests++;
    if ({rf_wen0, rf_wen1, busy, wb_count, rf_wdata0, rf_wdata1, rf_wdst0, rf_wdst1} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got wen=%b%b busy=%h cnt=%0d d0=%h d1=%h expected all zero",
               rf_wen0, rf_wen1, busy, wb_count, rf_wdata0, rf_wdata1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_tests++;
    if ({fpu_ready, ld_ready} !== 2'b11 || wb_count !== '0 || busy !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_release got rdy=%b%b cnt=%0d busy=%h expected 11/0/0",
               fpu_ready, ld_ready, wb_count, busy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({rf_wen0, rf_wen1} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_nowrite got wen=%b%b expected 00", rf_wen0, rf_wen1);
      end
    end
  endtask

  task automatic test_random();
    bit f = 1'b0;
    bit l = 1'b0;
    int exp_cnt;
    int drain = 0;
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    for (int c = 0; c < 10000; c++) begin
      if (!fpu_valid || f) begin
        fpu_valid = ($urandom_range(0, 99) < 60);
        fpu_dst = 4'($urandom_range(0, 15)); fpu_bank = 1'($urandom_range(0, 1)); fpu_data = $urandom;
      end
      if (!ld_valid || l) begin
        ld_valid = ($urandom_range(0, 99) < 50);
        ld_dst = 4'($urandom_range(0, 15)); ld_bank = 1'($urandom_range(0, 1)); ld_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_dst = 4'($urandom_range(0, 15)); issue_bank = 1'($urandom_range(0, 1));
      commit_and_step(f, l);
      exp_cnt = exp_q.size() - int'(rf_wen0) - int'(rf_wen1);
      n_tests++;
      if (int'(wb_count) !== exp_cnt || fpu_ready !== (DEPTH - exp_cnt >= 2) || ld_ready !== (DEPTH - exp_cnt >= 2)) begin
        n_fail++;
        $display("FAIL rand_count cycle=%0d got cnt=%0d rdy=%b%b expected cnt=%0d", c, wb_count, fpu_ready, ld_ready, exp_cnt);
      end
    end
    fpu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
    while (exp_q.size() != 0 && drain < 10) begin
      step();
      drain++;
    end
    step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain got pending=%0d expected=0", exp_q.size());
    end
    for (int r = 0; r < 32; r++) begin
      n_tests++;
      if (dut_rf[r] !== model_rf[r]) begin
        n_fail++;
        $display("FAIL rand_rf reg=%0d got=%h expected=%h", r, dut_rf[r], model_rf[r]);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mon_en = 1'b0;
    rst_n = 1'b1;
    issue_valid = 1'b0; issue_dst = '0; issue_bank = 1'b0;
    fpu_valid = 1'b0; fpu_dst = '0; fpu_bank = 1'b0; fpu_data = '0;
    ld_valid = 1'b0; ld_dst = '0; ld_bank = 1'b0; ld_data = '0;
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_pair();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
